// File: rtl/text_line_gen.sv
// text_line_gen: one writable line of NCHARS 8x16 glyphs placed at (X0, Y0).
// The pixel position is turned into a font ROM address (stage A). The box
// flag and glyph column are delayed to line up with the ROM data. Stage B then
// selects the lit bit and applies optional frame-counted blinking.
// Latency from pixel to text_on is ROM_LAT+2 clocks, one pixel per clock.
// The character write port is a plain strobe with no back-pressure:
// wr_en=1 at a rising edge stores wr_char into slot wr_idx, and any slot
// index >= NCHARS is silently dropped.
module text_line_gen #(
  parameter int NCHARS       = 8,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int ROM_LAT      = 1,
  parameter int BLINK_FRAMES = 30,
  localparam int IW          = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [6:0]    wr_char,
  input  logic          blink_en,
  output logic [10:0]   rom_addr,
  input  logic [7:0]    font_word,
  output logic          text_on
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Offsets are taken in 12 bits: a pixel left of / above the box wraps to a
  // large value, so one unsigned "< span" test covers both box edges.
  logic [11:0]   dx;
  logic [11:0]   dy;
  logic          in_box;
  logic [IW-1:0] idx;
  logic [2:0]    col;
  logic [3:0]    row;
  logic [6:0]    rd_char;

  logic [6:0]    char_buf [NCHARS];
  logic          flag_a;
  logic [2:0]    col_a;
  logic          flag_d [ROM_LAT];
  logic [2:0]    col_d  [ROM_LAT];
  logic [CW-1:0] frame_cnt;
  logic          blink_off;

  assign dx     = {2'b00, pixel_x} - 12'(X0);
  assign dy     = {2'b00, pixel_y} - 12'(Y0);
  assign in_box = video_on && (dx < 12'(8 * NCHARS)) && (dy < 12'd16);
  assign idx    = dx[IW+2:3];
  assign col    = dx[2:0];
  assign row    = dy[3:0];

  // Character lookup for the current slot; outside the box the result is unused.
  always_comb begin
    rd_char = 7'h00;
    for (int i = 0; i < NCHARS; i++) begin
      if (idx == IW'(i)) rd_char = char_buf[i];
    end
  end

  // Character buffer: the stage-A read in the same cycle still sees the old code.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCHARS; i++) char_buf[i] <= 7'h00;
    end else if (wr_en) begin
      for (int i = 0; i < NCHARS; i++) begin
        if (wr_idx == IW'(i)) char_buf[i] <= wr_char;
      end
    end
  end

  // Stage A: register ROM address plus the box flag and glyph column.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr <= 11'h000;
      flag_a   <= 1'b0;
      col_a    <= 3'd0;
    end else begin
      rom_addr <= in_box ? {rd_char, row} : {7'h00, pixel_y[3:0]};
      flag_a   <= in_box;
      col_a    <= col;
    end
  end

  // Delay flag and column by the ROM latency so they meet font_word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        flag_d[i] <= 1'b0;
        col_d[i]  <= 3'd0;
      end
    end else begin
      flag_d[0] <= flag_a;
      col_d[0]  <= col_a;
      for (int i = 1; i < ROM_LAT; i++) begin
        flag_d[i] <= flag_d[i-1];
        col_d[i]  <= col_d[i-1];
      end
    end
  end

  // Frame counter and blink phase; runs whether or not blinking is enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

  // Stage B: pick the glyph bit (bit 7 is leftmost) and apply blink gating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      text_on <= 1'b0;
    end else begin
      text_on <= flag_d[ROM_LAT-1] & font_word[3'd7 - col_d[ROM_LAT-1]]
                 & ~(blink_en & blink_off);
    end
  end

endmodule
